// File: rtl/rpn_prog_calc.sv
// Programmable RPN stack machine: host-loaded program memory, top-of-stack register plus below-top RAM.
// Optional extended opcodes (SUB, DUP, JZ) compiled in with RPN_PROG_CALC_EXT_OPS_EN.
module rpn_prog_calc #(
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int PAW   = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [PAW-1:0]             addr,
  input  logic [W-1:0]               datain,
  input  logic                       start,
  output logic                       ready,
  output logic [W-1:0]               out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err,
  output logic [1:0]                 err_code
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (W > DW) ? W : DW;

  typedef enum logic {S_READY, S_BUSY} state_t;

  state_t         state;
  logic [W-1:0]   prog [2**PAW];
  logic [W-1:0]   stk [DEPTH-1];
  logic [PAW-1:0] pc;
  logic [W-1:0]   top;

  logic [W-1:0]   p, b, ld_val;
  logic [DW-1:0]  dm1, dm2, lsel;
  logic           ld_ok;
  logic [W-1:0]   n_top;
  logic [DW-1:0]  n_depth;
  logic [PAW-1:0] n_pc;
  logic           fault, halt, sw_en;
  logic [1:0]     code;
  logic [AW-1:0]  sw_addr;
  logic [W-1:0]   sw_data;

  // top is forced to 0 whenever the stack empties, so it can drive out directly
  assign out = top;
  assign p   = prog[pc];
  assign dm1 = depth - DW'(1);
  assign dm2 = depth - DW'(2);
  assign b   = (depth >= DW'(2)) ? stk[dm2[AW-1:0]] : '0;

  assign ld_ok  = (depth >= DW'(2)) && (CW'(top) <= CW'(dm2));
  assign lsel   = dm2 - DW'(top);
  assign ld_val = ld_ok ? stk[lsel[AW-1:0]] : '0;

`ifdef RPN_PROG_CALC_EXT_OPS_EN
  logic [DW-1:0] dm3;
  logic [W-1:0]  c;
  assign dm3 = depth - DW'(3);
  assign c   = (depth >= DW'(3)) ? stk[dm3[AW-1:0]] : '0;
`endif

  always_comb begin
    n_top   = top;
    n_depth = depth;
    n_pc    = pc + PAW'(1);
    fault   = 1'b0;
    code    = 2'b00;
    halt    = 1'b0;
    sw_en   = 1'b0;
    sw_addr = dm1[AW-1:0];
    sw_data = top;
    if (!p[W-1]) begin
      if (depth == DW'(DEPTH)) begin
        fault = 1'b1; code = 2'b10;
      end else begin
        sw_en   = (depth != '0);
        n_top   = {1'b0, p[W-2:0]};
        n_depth = depth + DW'(1);
      end
    end else if (p[W-2]) begin
      halt = 1'b1;
      n_pc = pc;
    end else begin
      case (p[3:0])
        4'd0: if (depth == '0) begin fault = 1'b1; code = 2'b01; end
              else n_top = {{(W-1){1'b0}}, ~top[W-1] & (|top)};
        4'd1: if (depth == '0) begin fault = 1'b1; code = 2'b01; end
              else n_top = -top;
        4'd2: if (depth < DW'(2)) begin fault = 1'b1; code = 2'b01; end
              else begin n_top = b + top; n_depth = dm1; end
        4'd3: if (depth < DW'(2)) begin fault = 1'b1; code = 2'b01; end
              else begin n_top = b * top; n_depth = dm1; end
        4'd4: if (depth < DW'(2)) begin fault = 1'b1; code = 2'b01; end
              else begin n_top = b; sw_en = 1'b1; sw_addr = dm2[AW-1:0]; end
        4'd5: if (depth < DW'(2)) begin fault = 1'b1; code = 2'b01; end
              else if (!ld_ok) begin fault = 1'b1; code = 2'b11; end
              else n_top = ld_val;
        4'd6: if (depth == '0) begin fault = 1'b1; code = 2'b01; end
              else begin n_top = b; n_depth = dm1; end
        4'd7: if (depth == '0) begin fault = 1'b1; code = 2'b01; end
              else begin n_top = b; n_depth = dm1; n_pc = top[PAW-1:0]; end
`ifdef RPN_PROG_CALC_EXT_OPS_EN
        4'd8: if (depth < DW'(2)) begin fault = 1'b1; code = 2'b01; end
              else begin n_top = b - top; n_depth = dm1; end
        4'd9: if (depth == '0) begin fault = 1'b1; code = 2'b01; end
              else if (depth == DW'(DEPTH)) begin fault = 1'b1; code = 2'b10; end
              else begin sw_en = 1'b1; n_depth = depth + DW'(1); end
        4'd10: if (depth < DW'(2)) begin fault = 1'b1; code = 2'b01; end
               else begin
                 n_top   = c;
                 n_depth = dm2;
                 if (b == '0) n_pc = top[PAW-1:0];
               end
`endif
        default: begin fault = 1'b1; code = 2'b11; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_READY;
      ready    <= 1'b1;
      pc       <= '0;
      depth    <= '0;
      top      <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      case (state)
        S_READY: if (start) begin
          state    <= S_BUSY;
          ready    <= 1'b0;
          pc       <= '0;
          depth    <= '0;
          top      <= '0;
          err      <= 1'b0;
          err_code <= 2'b00;
        end
        S_BUSY: if (fault) begin
          state    <= S_READY;
          ready    <= 1'b1;
          err      <= 1'b1;
          err_code <= code;
        end else begin
          top   <= n_top;
          depth <= n_depth;
          pc    <= n_pc;
          if (halt) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        default: state <= S_READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_BUSY && sw_en) stk[sw_addr] <= sw_data;
  end

  always_ff @(posedge clk) begin
    if (wr && ready && !start) prog[addr] <= datain;
  end

endmodule

// File: tb/tb_rpn_prog_calc.sv
// Directed bench for rpn_prog_calc (W=16, DEPTH=4); expectations adapt to RPN_PROG_CALC_EXT_OPS_EN.
module tb_rpn_prog_calc;
  localparam int W = 16, DEPTH = 4, PAW = 10;
  localparam logic [15:0] HALT = 16'hC000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr = 1'b0;
  logic [PAW-1:0] addr = '0;
  logic [W-1:0]   datain = '0;
  logic           start = 1'b0;
  logic           ready;
  logic [W-1:0]   out;
  logic [2:0]     depth;
  logic           err;
  logic [1:0]     err_code;

  int checks = 0, errors = 0;
  logic [15:0] q [$];
  logic [15:0] trace [256];
  int cyc;
  logic wr_with_start = 1'b0;

  rpn_prog_calc #(.W(W), .DEPTH(DEPTH), .PAW(PAW)) dut (
    .clk(clk), .rst(rst), .wr(wr), .addr(addr), .datain(datain), .start(start),
    .ready(ready), .out(out), .depth(depth), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] op(input int n);
    op = 16'h8000 | 16'(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      wr = 1'b1; addr = PAW'(i); datain = q[i];
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic run(output int n);
    @(negedge clk);
    start = 1'b1;
    if (wr_with_start) begin wr = 1'b1; addr = '0; datain = 16'd9; end
    @(posedge clk);
    #1;
    start = 1'b0; wr = 1'b0;
    check("busy_after_start", 32'(ready), 0);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      trace[n] = out;
      n++;
      if (ready) break;
    end
    check("run_done", 32'(ready), 1);
  endtask

  task automatic expect_end(input string tag, input logic [15:0] o, input int d,
                            input logic e, input logic [1:0] ec);
    check({tag, "_out"}, 32'(out), 32'(o));
    check({tag, "_depth"}, 32'(depth), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_code"}, 32'(err_code), 32'(ec));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready), 1);
    expect_end("rst", 16'd0, 0, 1'b0, 2'b00);

    q = '{16'd2, 16'd3, op(2), 16'd4, op(3), HALT};
    load(); run(cyc);
    check("arith_cycles", 32'(cyc), 6);
    expect_end("arith", 16'd20, 1, 1'b0, 2'b00);

    q = '{16'd5, op(1), op(0), HALT};
    load(); run(cyc);
    check("neg_mid", 32'(trace[1]), 32'hFFFB);
    check("neg_cycles", 32'(cyc), 4);
    expect_end("neg_gt", 16'd0, 1, 1'b0, 2'b00);

    q = '{16'd7, op(0), HALT};
    load(); run(cyc);
    expect_end("gt_pos", 16'd1, 1, 1'b0, 2'b00);

    q = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, HALT};
    load(); run(cyc);
    check("ovf_cycles", 32'(cyc), 5);
    expect_end("ovf", 16'd1, 4, 1'b1, 2'b10);

    q = '{16'd9, op(2), HALT};
    load(); run(cyc);
    expect_end("unf_add", 16'd9, 1, 1'b1, 2'b01);

    q = '{16'd1, 16'd2, op(4), op(6), HALT};
    load(); run(cyc);
    expect_end("swap_pop", 16'd2, 1, 1'b0, 2'b00);

    q = '{16'd10, 16'd20, 16'd30, 16'd1, op(5), HALT};
    load(); run(cyc);
    expect_end("load_k1", 16'd20, 4, 1'b0, 2'b00);
    q[3] = 16'd2;
    load(); run(cyc);
    expect_end("load_k2", 16'd10, 4, 1'b0, 2'b00);
    q[3] = 16'd3;
    load(); run(cyc);
    expect_end("load_range", 16'd3, 4, 1'b1, 2'b11);

    q = '{op(6), HALT};
    load(); run(cyc);
    expect_end("pop_empty", 16'd0, 0, 1'b1, 2'b01);

    q = '{16'd1, op(11), HALT};
    load(); run(cyc);
    expect_end("illegal11", 16'd1, 1, 1'b1, 2'b11);

    q = '{16'd3, 16'd1, op(8), op(9), 16'd8, op(10), 16'd1, op(7), HALT};
    load(); run(cyc);
`ifdef RPN_PROG_CALC_EXT_OPS_EN
    check("countdown_cycles", 32'(cyc), 21);
    expect_end("countdown", 16'd0, 1, 1'b0, 2'b00);
`else
    check("countdown_cycles", 32'(cyc), 3);
    expect_end("countdown", 16'd1, 2, 1'b1, 2'b11);
`endif

    q = '{16'd7, 16'd1, op(7)};
    load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("loop_busy", 32'(ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 32'(ready), 1);
    expect_end("abort", 16'd0, 0, 1'b0, 2'b00);
    @(negedge clk); rst = 1'b0;

    q = '{16'd5, HALT};
    load();
    wr_with_start = 1'b1;
    run(cyc);
    wr_with_start = 1'b0;
    expect_end("start_wr", 16'd5, 1, 1'b0, 2'b00);
    run(cyc);
    check("start_wr_again", 32'(out), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
